if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction Fetch stage of the 5-stage MIPS pipeline, directly upstream of the Instruction Decode stage. Owns the PC, issues word fetches to a variable-latency instruction memory, applies branch/jump redirects and hazard-unit stall/flush, and drives the IF/ID pipeline register (instruction_D, pc_plus_4_D, valid_D) that Decode consumes.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
stall_F  input  1  hazard unit: freeze PC and IF/ID
flush_D  input  1  hazard unit: clear IF/ID to bubble
pc_src_D  input  1  branch taken, resolved in Decode
branch_target_D  input  32  branch destination
jump_D  input  1  jump taken
jump_target_D  input  32  jump destination
imem_req  output  1  fetch request (level)
imem_addr  output  32  word address of fetch (PC)
imem_ready  input  1  response valid for current imem_addr
imem_rdata  input  32  fetched instruction
instruction_D  output  32  IF/ID instruction
pc_plus_4_D  output  32  IF/ID PC+4
valid_D  output  1  IF/ID holds a real instruction
fetch_busy  output  1  fetch outstanding, no data yet (to hazard unit)

Behaviour:
- Reset (sync): PC=RESET_PC, state=FETCH, skid empty, instruction_D=NOP_INSTR, pc_plus_4_D=0, valid_D=0. Reset beats every other input; reset mid-fetch abandons the access (the memory must tolerate imem_req/imem_addr changing during reset).
- imem_addr=PC always; PC[1:0] is always 00; targets with nonzero [1:0] are forced to 00.
- Memory protocol: imem_req high in FETCH and DRAIN, low in HOLD. While imem_req=1 and imem_ready=0, imem_addr is held stable. imem_ready may arrive the same cycle (zero-wait) or N cycles later.
- Redirect = jump_D | pc_src_D; jump_D has priority over pc_src_D. Target = jump_D ? jump_target_D : branch_target_D.
- FSM:
  FETCH: ready & redirect -> discard data, PC<=target, stay FETCH. ready & !stall_F -> IF/ID<=(rdata, PC+4, 1), PC<=PC+4, stay. ready & stall_F -> skid<=(rdata, PC+4), PC<=PC+4, go HOLD. !ready & redirect -> pend<=target, go DRAIN. !ready -> stay.
  HOLD: redirect -> drop skid, PC<=target, go FETCH. !stall_F -> IF/ID<=skid (valid 1), go FETCH. Else stay.
  DRAIN: on ready, discard data, PC<=pend, go FETCH. A second redirect in DRAIN overwrites pend (latest wins).
- IF/ID update priority: reset > flush_D > stall_F (hold) > new instruction > bubble. flush_D loads NOP_INSTR/0/0 even while stall_F=1. If not stalled and no instruction is delivered this cycle, load a bubble.
- Redirect is honoured even with stall_F=1: the PC/pend updates, and IF/ID follows the priority above.
- fetch_busy = imem_req & !imem_ready.
- PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).

Decomposition:
- Shared package holds: the FSM state enum (FETCH, HOLD, DRAIN), RESET_PC and NOP_INSTR defaults, and the IF/ID bundle typedef (instr, pc_plus_4, valid), reused by the Decode stage.
- One natural sub-module: if_id_reg (IF/ID register with flush/stall/bubble priority). PC logic and the FSM stay in if_stage.

Test Plan:
- Reset, then zero-wait memory returning 0x2008_0005 -> imem_addr 0x0040_0000, 0x0040_0004, …; next cycle instruction_D=0x2008_0005, pc_plus_4_D=0x0040_0004, valid_D=1.
- Memory with 3-cycle latency -> fetch_busy=1 for 2 cycles, imem_addr stable; valid_D=0 bubbles until data arrives.
- stall_F=1 when ready arrives -> state HOLD, imem_req=0, IF/ID unchanged; release stall -> skid word appears in IF/ID, one cycle later fetch resumes at PC+4.
- pc_src_D=1, target 0x0040_0100, while a fetch is outstanding (latency 2) -> DRAIN; the returned word is never valid; next imem_addr=0x0040_0100.
- jump_D and pc_src_D together (jump 0x0040_0200, branch 0x0040_0300) -> PC=0x0040_0200; flush_D together with stall_F -> instruction_D=0, valid_D=0.
- PC forced to 0xFFFF_FFFC -> next fetch address 0x0000_0000, pc_plus_4_D=0x0000_0000; assert reset during DRAIN -> PC=RESET_PC, valid_D=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage and the IF/ID register.
// Decode also imports the IF/ID bundle from here.
package if_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset, then flush, then stall (hold), then a newly
// delivered instruction, otherwise a bubble.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   stall,
    input  logic   load,
    input  if_id_t load_data,
    output if_id_t if_id
);

    if_id_t bubble;

    assign bubble = '{instr: NOP_INSTR, pc_plus_4: 32'h0, valid: 1'b0};

    // Flush wins over stall so a squashed slot never survives a frozen pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id <= bubble;
        end else if (flush) begin
            if_id <= bubble;
        end else if (stall) begin
            if_id <= if_id;
        end else if (load) begin
            if_id <= load_data;
        end else begin
            if_id <= bubble;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction fetch stage: owns the PC, talks to a variable-latency
// instruction memory, applies redirects and drives the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        flush_D,
    input  logic        pc_src_D,
    input  logic [31:0] branch_target_D,
    input  logic        jump_D,
    input  logic [31:0] jump_target_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_D,
    output logic [31:0] pc_plus_4_D,
    output logic        valid_D,
    output logic        fetch_busy
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  pend, pend_next;
    logic [31:0]  skid_instr, skid_instr_next;
    logic [31:0]  skid_pc4, skid_pc4_next;
    logic [31:0]  pc_plus_4;
    logic         redirect;
    logic [31:0]  target;
    logic         load;
    if_id_t       load_data;
    if_id_t       if_id_q;

    assign pc_plus_4 = pc + 32'd4;
    assign redirect  = jump_D | pc_src_D;
    assign target    = word_align(jump_D ? jump_target_D : branch_target_D);

    assign imem_req   = (state != HOLD);
    assign imem_addr  = pc;
    assign fetch_busy = imem_req & ~imem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pend       <= 32'h0;
            skid_instr <= 32'h0;
            skid_pc4   <= 32'h0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pend       <= pend_next;
            skid_instr <= skid_instr_next;
            skid_pc4   <= skid_pc4_next;
        end
    end

    // PC only moves when the memory has answered, so imem_addr stays stable
    // for the whole of an outstanding access (including while draining).
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pend_next       = pend;
        skid_instr_next = skid_instr;
        skid_pc4_next   = skid_pc4;
        load            = 1'b0;
        load_data       = '0;

        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_next = target;
                    end else if (!stall_F) begin
                        load      = 1'b1;
                        load_data = '{instr: imem_rdata, pc_plus_4: pc_plus_4, valid: 1'b1};
                        pc_next   = pc_plus_4;
                    end else begin
                        skid_instr_next = imem_rdata;
                        skid_pc4_next   = pc_plus_4;
                        pc_next         = pc_plus_4;
                        state_next      = HOLD;
                    end
                end else if (redirect) begin
                    pend_next  = target;
                    state_next = DRAIN;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (!stall_F) begin
                    load       = 1'b1;
                    load_data  = '{instr: skid_instr, pc_plus_4: skid_pc4, valid: 1'b1};
                    state_next = FETCH;
                end
            end

            DRAIN: begin
                // A redirect landing with the drained response still wins.
                if (redirect) begin
                    pend_next = target;
                end
                if (imem_ready) begin
                    pc_next    = redirect ? target : pend;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_D),
        .stall    (stall_F),
        .load     (load),
        .load_data(load_data),
        .if_id    (if_id_q)
    );

    assign instruction_D = if_id_q.instr;
    assign pc_plus_4_D   = if_id_q.pc_plus_4;
    assign valid_D       = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random traffic,
// compared against a transaction-level model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int M_FETCH = 0;
    localparam int M_HOLD  = 1;
    localparam int M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_F, flush_D, pc_src_D, jump_D;
    logic [31:0] branch_target_D, jump_target_D;
    logic        imem_req, imem_ready, valid_D, fetch_busy;
    logic [31:0] imem_addr, imem_rdata, instruction_D, pc_plus_4_D;

    int checks = 0;
    int failures = 0;
    bit check_en = 0;
    bit mem_const = 0;
    int lat_cycles = 1;
    int waited = 0;
    int busy_seen = 0;

    // Reference model state
    logic [31:0] m_pc = RST_PC;
    int          m_mode = M_FETCH;
    logic [31:0] m_pend = 32'h0;
    logic [31:0] m_skid_i = 32'h0;
    logic [31:0] m_skid_p = 32'h0;
    logic [31:0] m_if_i = 32'h0;
    logic [31:0] m_if_p = 32'h0;
    logic        m_if_v = 1'b0;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall_F        (stall_F),
        .flush_D        (flush_D),
        .pc_src_D       (pc_src_D),
        .branch_target_D(branch_target_D),
        .jump_D         (jump_D),
        .jump_target_D  (jump_target_D),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instruction_D  (instruction_D),
        .pc_plus_4_D    (pc_plus_4_D),
        .valid_D        (valid_D),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[7:0], addr[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit stall, input bit flush,
                                 input bit pcsrc, input logic [31:0] bt,
                                 input bit jump, input logic [31:0] jt);
        bit          req_m, ready, redir, got;
        logic [31:0] tgt, rdata, g_i, g_p;
        @(negedge clk);
        reset = rst;
        stall_F = stall;
        flush_D = flush;
        pc_src_D = pcsrc;
        branch_target_D = bt;
        jump_D = jump;
        jump_target_D = jt;
        req_m = (m_mode != M_HOLD);
        ready = req_m && (waited >= lat_cycles - 1);
        rdata = ready ? (mem_const ? 32'h2008_0005 : mem_word(m_pc)) : $urandom;
        imem_ready = ready;
        imem_rdata = rdata;
        #1;
        if (fetch_busy === 1'b1) busy_seen++;
        if (check_en) begin
            checkOutput("imem_req", 32'(imem_req), 32'(req_m));
            checkOutput("fetch_busy", 32'(fetch_busy), 32'(req_m & ~ready));
            checkOutput("imem_addr_pre", imem_addr, m_pc);
        end

        got = 0;
        g_i = 32'h0;
        g_p = 32'h0;
        if (rst) begin
            m_pc = RST_PC; m_mode = M_FETCH; m_pend = 0; m_skid_i = 0; m_skid_p = 0;
            m_if_i = 0; m_if_p = 0; m_if_v = 0;
            waited = 0;
        end else begin
            redir = jump | pcsrc;
            tgt = (jump ? jt : bt) & 32'hFFFF_FFFC;
            if (m_mode == M_FETCH) begin
                if (ready) begin
                    if (redir) m_pc = tgt;
                    else if (!stall) begin
                        got = 1; g_i = rdata; g_p = m_pc + 32'd4; m_pc = m_pc + 32'd4;
                    end else begin
                        m_skid_i = rdata; m_skid_p = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_mode = M_HOLD;
                    end
                end else if (redir) begin
                    m_pend = tgt; m_mode = M_DRAIN;
                end
            end else if (m_mode == M_HOLD) begin
                if (redir) begin
                    m_pc = tgt; m_mode = M_FETCH;
                end else if (!stall) begin
                    got = 1; g_i = m_skid_i; g_p = m_skid_p; m_mode = M_FETCH;
                end
            end else begin
                if (redir) m_pend = tgt;
                if (ready) begin
                    m_pc = m_pend; m_mode = M_FETCH;
                end
            end
            if (flush) begin
                m_if_i = 0; m_if_p = 0; m_if_v = 0;
            end else if (!stall) begin
                m_if_i = got ? g_i : 32'h0;
                m_if_p = got ? g_p : 32'h0;
                m_if_v = got;
            end
            if (req_m) waited = ready ? 0 : waited + 1;
        end

        @(posedge clk);
        #1;
        checkOutput("imem_addr", imem_addr, m_pc);
        checkOutput("instruction_D", instruction_D, m_if_i);
        checkOutput("pc_plus_4_D", pc_plus_4_D, m_if_p);
        checkOutput("valid_D", 32'(valid_D), 32'(m_if_v));
        check_en = 1;
    endtask

    initial begin
        reset = 1; stall_F = 0; flush_D = 0; pc_src_D = 0; jump_D = 0;
        branch_target_D = 0; jump_target_D = 0; imem_ready = 0; imem_rdata = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_addr", imem_addr, 32'h0040_0000);
        checkOutput("reset_valid", 32'(valid_D), 32'h0);

        // Zero-wait memory returning a constant word
        mem_const = 1;
        lat_cycles = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("zw_instr", instruction_D, 32'h2008_0005);
        checkOutput("zw_pc4", pc_plus_4_D, 32'h0040_0004);
        checkOutput("zw_addr", imem_addr, 32'h0040_0004);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("zw_addr2", imem_addr, 32'h0040_0008);
        mem_const = 0;

        // Three-cycle latency
        lat_cycles = 3;
        busy_seen = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("lat_bubble", 32'(valid_D), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("lat_busy_cycles", 32'(busy_seen), 32'd2);
        checkOutput("lat_valid", 32'(valid_D), 32'h1);

        // Stall as data arrives, then release
        lat_cycles = 1;
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("hold_req", 32'(imem_req), 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("skid_valid", 32'(valid_D), 32'h1);
        checkOutput("skid_pc4", pc_plus_4_D, 32'h0040_0010);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Branch while a fetch is outstanding
        lat_cycles = 2;
        applyStimulus(0, 0, 0, 1, 32'h0040_0100, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("drain_addr", imem_addr, 32'h0040_0100);
        checkOutput("drain_valid", 32'(valid_D), 32'h0);

        // Jump beats branch; flush beats stall
        lat_cycles = 1;
        applyStimulus(0, 0, 0, 1, 32'h0040_0300, 1, 32'h0040_0200);
        checkOutput("jump_prio", imem_addr, 32'h0040_0200);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("flush_instr", instruction_D, 32'h0);
        checkOutput("flush_valid", 32'(valid_D), 32'h0);

        // Unaligned jump to the top of memory, then wrap
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
        checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
        checkOutput("wrap_pc4", pc_plus_4_D, 32'h0000_0000);
        checkOutput("wrap_valid", 32'(valid_D), 32'h1);

        // Reset while draining
        lat_cycles = 3;
        applyStimulus(0, 0, 0, 1, 32'h0040_0500, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_drain_addr", imem_addr, RST_PC);
        checkOutput("rst_drain_valid", 32'(valid_D), 32'h0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] bt, jt;
            if (waited == 0) lat_cycles = $urandom_range(1, 4);
            bt = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 | ($urandom % 8) : $urandom;
            jt = $urandom;
            applyStimulus(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                          ($urandom % 8) == 0, bt, ($urandom % 10) == 0, jt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
